dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported data memory between the pipeline's MEM stage and an external master port (test bench loader / debug DMA). Core accesses always pass through with zero added latency. External beats are granted opportunistically in cycles where the core does not touch memory. A starving external master forces a drain: `core_hold` freezes PC fetch, in-flight instructions retire, then a bounded external burst runs. Sits between the EX/MEM pipeline register outputs and `datamemory`; `core_hold` is ORed into the datapath's Halt.

## Interface
- DM_ADDRESS, 9, data memory address width
- DATA_W, 32, data word width
- STARVE_MAX, 8, consecutive denied ext-request cycles before a forced drain (≥1)
- DRAIN_CYC, 3, cycles `core_hold` is held before the ext burst starts (covers ID/EX/MEM in flight)
- BURST_MAX, 4, max ext beats per forced burst (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- core_rd, core_wr  in  1 each  MEM-stage read/write enables
- core_addr  in  DM_ADDRESS  MEM-stage address
- core_wdata  in  DATA_W  store data
- core_funct3  in  3  access size/sign
- core_rdata  out  DATA_W  equals mem_rdata, combinational
- core_hold  out  1  request to stall PC fetch
- ext_req  in  1  ext master wants a beat
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  DM_ADDRESS  ext address
- ext_wdata  in  DATA_W  ext write data
- ext_gnt  out  1  beat accepted this cycle, combinational
- ext_rvalid  out  1  read data valid, one cycle after granted read beat
- ext_rdata  out  DATA_W  registered read data
- mem_rd, mem_wr  out  1 each  to datamemory
- mem_addr  out  DM_ADDRESS  to datamemory
- mem_wdata  out  DATA_W  to datamemory
- mem_funct3  out  3  to datamemory
- mem_rdata  in  DATA_W  datamemory read data, combinational
- proto_err  out  1  sticky: core access during S_EXT
- arb_state  out  2  current state, for debug

## Operation
- States: S_CORE (0), S_DRAIN (1), S_EXT (2). Encoding 3 is unreachable and decodes as S_CORE.
- Core access = core_rd | core_wr. Core access always wins the memory in every state. Mem outputs then mirror the core inputs.
- Ext grant: ext_gnt = ext_req & !core access & (state ≠ S_DRAIN) & !reset.
  - On grant, mem_rd = !ext_we, mem_wr = ext_we, addr/wdata come from ext, mem_funct3 = 3'b010 (word).
- No owner: mem_rd = mem_wr = 0. addr/wdata/funct3 hold the core inputs.
- starve_cnt:
  - In S_CORE: increments on ext_req & !ext_gnt. Clears on ext_gnt or !ext_req.
  - At starve_cnt == STARVE_MAX−1 with another denial: go to S_DRAIN, load drain_cnt = DRAIN_CYC−1.
- S_DRAIN: core_hold = 1, no ext grants, drain_cnt decrements each cycle. At 0, go to S_EXT with beat_cnt = 0.
- S_EXT: core_hold = 1. Each ext_gnt increments beat_cnt.
  - Returns to S_CORE after the grant making beat_cnt == BURST_MAX, or in the first cycle with !ext_req.
  - starve_cnt clears on that return.
- Core access in S_EXT: core wins, ext_gnt = 0, proto_err sets and stays set until reset.
- ext_rvalid/ext_rdata: registered on a granted read beat (ext_rdata <= mem_rdata). ext_rvalid is 0 otherwise.

## Timing
- Reset values: state S_CORE, starve_cnt 0, drain_cnt 0, beat_cnt 0, core_hold 0, ext_rvalid 0, ext_rdata 0, proto_err 0, ext_gnt 0.
- Core path: zero latency, purely combinational through the muxes.
- core_hold is registered, decoded from state. It asserts the cycle after the STARVE_MAX-th denial and deasserts the cycle after the last burst beat.
- Ext read latency: 1 cycle from gnt to rvalid. Back-to-back beats give rvalid every cycle.
- Ext master must hold req/we/addr/wdata stable until gnt.
- Simultaneous ext_req and core access in S_CORE: core served, counts as a denial.
- Reset mid-burst: state returns to S_CORE next edge and a pending rvalid is dropped (0).

## Structure
- Package dmem_arb_pkg: typedef enum logic [1:0] arb_state_t {S_CORE, S_DRAIN, S_EXT}; localparam FUNCT3_WORD = 3'b010.
- One sub-module: arb_down_counter (load/decrement/zero flag), instanced for drain_cnt.
- starve_cnt and beat_cnt live inline.

## Test plan
- Idle core; ext read addr 0x010 → ext_gnt same cycle, mem_rd=1, ext_rvalid=1 next cycle with the stored word. core_hold stays 0.
- Core lw at 0x020 concurrent with ext write → core served, ext_gnt=0. Core idle next cycle → ext granted, mem_wr=1, mem_funct3=010.
- Core accesses every cycle, ext_req held → after 8 denials core_hold=1. 3 drain cycles with core loads passing through. Then 4 ext beats granted, core_hold=0 the cycle after the 4th.
- Forced burst with ext_req dropping after 2 beats → return to S_CORE after 2 beats, starve_cnt=0.
- Core write injected in S_EXT → core write reaches mem, ext_gnt=0, proto_err=1 until reset.
- Reset asserted in S_EXT with a read pending → next cycle state=S_CORE, core_hold=0, ext_rvalid=0, proto_err=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t - arbiter FSM states (encoding 3 is unused, decodes as S_CORE)
//   FUNCT3_WORD - access size used for every external-master beat
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_CORE  = 2'd0,
        S_DRAIN = 2'd1,
        S_EXT   = 2'd2
    } arb_state_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter_down_counter.sv
// arb_down_counter: loadable down counter that saturates at zero.
//   clk, reset - clock, synchronous active-high reset (count clears to 0)
//   load       - load load_val (has priority over dec)
//   load_val   - value to load
//   dec        - decrement by one, ignored once the count is zero
//   zero       - count is zero
module arb_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the MEM stage
// and an external master. Core accesses pass through combinationally and
// always win. External beats use idle core cycles; a starved master forces a
// drain (core_hold) followed by a bounded external burst.
//   core_*   - MEM-stage request, core_rdata mirrors mem_rdata
//   core_hold- registered stall request for PC fetch (high in S_DRAIN/S_EXT)
//   ext_*    - external master port; ext_gnt combinational, read data one
//              cycle after a granted read beat
//   mem_*    - to/from datamemory (mem_rdata combinational)
//   proto_err- sticky: core touched memory while the burst owned it
//   arb_state- current state for debug
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int DRAIN_CYC  = 3,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_hold,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [DM_ADDRESS-1:0] ext_addr,
    input  logic [DATA_W-1:0]     ext_wdata,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_W-1:0]     ext_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  proto_err,
    output logic [1:0]            arb_state
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
    localparam logic [BW-1:0] BEAT_LAST   = BW'(BURST_MAX - 1);
    localparam logic [DW-1:0] DRAIN_LOAD  = DW'(DRAIN_CYC - 1);

    logic [1:0]    state_q;
    arb_state_t    st, st_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic          drain_load, drain_dec, drain_zero;
    logic          core_acc;

    // Unused encoding folds back to S_CORE.
    always_comb begin
        case (state_q)
            2'd1:    st = S_DRAIN;
            2'd2:    st = S_EXT;
            default: st = S_CORE;
        endcase
    end

    assign arb_state  = st;
    assign core_acc   = core_rd | core_wr;
    assign core_rdata = mem_rdata;
    assign ext_gnt    = ext_req & ~core_acc & (st != S_DRAIN) & ~reset;

    // Memory mux: ext only when granted, otherwise the core inputs pass
    // through (with no core access that leaves rd/wr low).
    always_comb begin
        mem_rd     = core_rd;
        mem_wr     = core_wr;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_funct3 = core_funct3;
        if (ext_gnt) begin
            mem_rd     = ~ext_we;
            mem_wr     = ext_we;
            mem_addr   = ext_addr;
            mem_wdata  = ext_wdata;
            mem_funct3 = FUNCT3_WORD;
        end
    end

    always_comb begin
        st_nxt     = st;
        starve_nxt = starve_cnt;
        beat_nxt   = beat_cnt;
        drain_load = 1'b0;
        drain_dec  = 1'b0;
        case (st)
            S_CORE: begin
                if (ext_req && !ext_gnt) begin
                    starve_nxt = starve_cnt + 1'b1;
                    if (starve_cnt == STARVE_LAST) begin
                        st_nxt     = S_DRAIN;
                        drain_load = 1'b1;
                    end
                end else begin
                    starve_nxt = '0;
                end
            end
            S_DRAIN: begin
                drain_dec = 1'b1;
                if (drain_zero) begin
                    st_nxt   = S_EXT;
                    beat_nxt = '0;
                end
            end
            default: begin
                if (ext_gnt)
                    beat_nxt = beat_cnt + 1'b1;
                // Burst ends on the last allowed beat or as soon as the
                // master stops asking.
                if ((ext_gnt && beat_cnt == BEAT_LAST) || !ext_req) begin
                    st_nxt     = S_CORE;
                    starve_nxt = '0;
                end
            end
        endcase
    end

    arb_down_counter #(.W(DW)) u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (drain_load),
        .load_val (DRAIN_LOAD),
        .dec      (drain_dec),
        .zero     (drain_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_CORE;
            starve_cnt <= '0;
            beat_cnt   <= '0;
            core_hold  <= 1'b0;
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
            proto_err  <= 1'b0;
        end else begin
            state_q    <= st_nxt;
            starve_cnt <= starve_nxt;
            beat_cnt   <= beat_nxt;
            core_hold  <= (st_nxt != S_CORE);
            ext_rvalid <= ext_gnt & ~ext_we;
            if (ext_gnt && !ext_we)
                ext_rdata <= mem_rdata;
            if (core_acc && st == S_EXT)
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a cycle-level behavioural model and a
// small word memory standing in for datamemory.
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int SM = 8;
    localparam int DC = 3;
    localparam int BM = 4;

    logic          clk, reset;
    logic          core_rd, core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [2:0]    core_funct3;
    logic [DW-1:0] core_rdata;
    logic          core_hold;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
    logic          proto_err;
    logic [1:0]    arb_state;

    dmem_arbiter #(
        .DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(SM),
        .DRAIN_CYC(DC), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_hold(core_hold),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .proto_err(proto_err), .arb_state(arb_state)
    );

    logic [DW-1:0] bmem [0:511];
    assign mem_rdata = bmem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // Model: hold phase tracked as "cycles since the hold began".
    bit            m_hold = 0;
    int            m_denials = 0, m_age = 0, m_beats = 0;
    bit            m_rvalid = 0, m_perr = 0;
    logic [DW-1:0] m_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        int            phase;
        bit            ca, eg;
        bit            e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [2:0]    e_f3;
        phase = !m_hold ? 0 : ((m_age < DC) ? 1 : 2);
        ca = core_rd | core_wr;
        eg = ext_req && !ca && phase != 1 && !reset;
        if (eg) begin
            e_rd = !ext_we; e_wr = ext_we; e_addr = ext_addr;
            e_wdata = ext_wdata; e_f3 = 3'b010;
        end else begin
            e_rd = core_rd; e_wr = core_wr; e_addr = core_addr;
            e_wdata = core_wdata; e_f3 = core_funct3;
        end
        chk("ext_gnt", ext_gnt, eg);
        chk("mem_rd", mem_rd, e_rd);
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_funct3", mem_funct3, e_f3);
        chk("core_rdata", core_rdata, bmem[e_addr]);
        chk("arb_state", arb_state, phase);
        chk("core_hold", core_hold, m_hold);
        chk("ext_rvalid", ext_rvalid, m_rvalid);
        chk("ext_rdata", ext_rdata, m_rdata);
        chk("proto_err", proto_err, m_perr);
        if (reset) begin
            m_hold = 0; m_denials = 0; m_age = 0; m_beats = 0;
            m_rvalid = 0; m_perr = 0; m_rdata = '0;
        end else begin
            m_rvalid = eg && !ext_we;
            if (m_rvalid) m_rdata = bmem[ext_addr];
            if (ca && phase == 2) m_perr = 1;
            case (phase)
                0: begin
                    if (ext_req && !eg) begin
                        m_denials++;
                        if (m_denials == SM) begin
                            m_hold = 1; m_age = 0; m_beats = 0;
                        end
                    end else begin
                        m_denials = 0;
                    end
                end
                1: m_age++;
                default: begin
                    if (eg) m_beats++;
                    if (m_beats == BM || !ext_req) begin
                        m_hold = 0; m_denials = 0;
                    end
                end
            endcase
        end
    endtask

    // One clock: check/advance model at negedge, apply memory write at the
    // edge, return 1 time unit after the edge.
    task automatic step();
        bit            w_en;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        @(negedge clk);
        if (chk_en) model_cycle();
        w_en = mem_wr; w_addr = mem_addr; w_data = mem_wdata;
        @(posedge clk);
        if (w_en) bmem[w_addr] = w_data;
        #1;
    endtask

    task automatic drive_core(input bit rd, input bit wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [2:0] f3);
        core_rd = rd; core_wr = wr; core_addr = a; core_wdata = d; core_funct3 = f3;
    endtask

    task automatic drive_ext(input bit req, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
    endtask

    task automatic starve(input int n);
        for (int i = 0; i < n; i++) begin
            drive_core(1, 0, AW'(9'h100 + i), '0, 3'b010);
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) bmem[i] = 32'hD000_0000 | i;
        bmem[9'h010] = 32'hCAFE_0010;
        bmem[9'h060] = 32'h6060_6060;
        drive_core(0, 0, '0, '0, 3'b000);
        drive_ext(0, 0, '0, '0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1;
        step();
        reset = 1'b0;
        chk("rst_state", arb_state, 2'd0);
        chk("rst_hold", core_hold, 1'b0);
        chk("rst_rvalid", ext_rvalid, 1'b0);
        chk("rst_rdata", ext_rdata, 32'h0);
        chk("rst_perr", proto_err, 1'b0);

        // idle core, ext read
        drive_ext(1, 0, 9'h010, '0);
        #1;
        chk("t1_gnt", ext_gnt, 1'b1);
        chk("t1_mem_rd", mem_rd, 1'b1);
        step();
        drive_ext(0, 0, '0, '0);
        chk("t1_rvalid", ext_rvalid, 1'b1);
        chk("t1_rdata", ext_rdata, 32'hCAFE_0010);
        chk("t1_hold", core_hold, 1'b0);
        step();

        // core load collides with ext write, ext goes next cycle
        drive_core(1, 0, 9'h020, '0, 3'b010);
        drive_ext(1, 1, 9'h030, 32'h1234_5678);
        #1;
        chk("t2_gnt_blk", ext_gnt, 1'b0);
        chk("t2_core_addr", mem_addr, 9'h020);
        step();
        drive_core(0, 0, 9'h020, '0, 3'b000);
        #1;
        chk("t2_gnt", ext_gnt, 1'b1);
        chk("t2_mem_wr", mem_wr, 1'b1);
        chk("t2_f3", mem_funct3, 3'b010);
        step();
        drive_ext(0, 0, '0, '0);
        chk("t2_memword", bmem[9'h030], 32'h1234_5678);
        step();

        // full forced drain + burst
        drive_ext(1, 0, 9'h040, '0);
        starve(SM - 1);
        chk("t3_hold_pre", core_hold, 1'b0);
        starve(1);
        chk("t3_hold_on", core_hold, 1'b1);
        chk("t3_drain", arb_state, 2'd1);
        starve(DC);
        chk("t3_ext", arb_state, 2'd2);
        drive_core(0, 0, '0, '0, 3'b000);
        for (int b = 0; b < BM; b++) begin
            drive_ext(1, 0, AW'(9'h040 + b), '0);
            step();
            if (b == BM - 2) chk("t3_hold_mid", core_hold, 1'b1);
        end
        chk("t3_hold_off", core_hold, 1'b0);
        drive_ext(0, 0, '0, '0);
        step();

        // burst cut short by master after 2 beats
        drive_ext(1, 0, 9'h044, '0);
        starve(SM + DC);
        drive_core(0, 0, '0, '0, 3'b000);
        step();
        step();
        drive_ext(0, 0, '0, '0);
        step();
        chk("t4_hold_off", core_hold, 1'b0);
        chk("t4_state", arb_state, 2'd0);
        // starvation count restarted from zero
        drive_ext(1, 0, 9'h048, '0);
        starve(SM - 1);
        chk("t4_restart", core_hold, 1'b0);
        starve(1);
        chk("t5_hold_on", core_hold, 1'b1);

        // core write during burst, then reset with read pending
        starve(DC);
        drive_core(0, 0, '0, '0, 3'b000);
        drive_ext(1, 0, 9'h070, '0);
        step();
        drive_core(0, 1, 9'h050, 32'hAAAA_5555, 3'b010);
        drive_ext(1, 0, 9'h060, '0);
        #1;
        chk("t5_gnt_blk", ext_gnt, 1'b0);
        chk("t5_core_wr", mem_wr, 1'b1);
        chk("t5_core_addr", mem_addr, 9'h050);
        step();
        chk("t5_perr", proto_err, 1'b1);
        drive_core(0, 0, '0, '0, 3'b000);
        step();
        chk("t5_perr_sticky", proto_err, 1'b1);
        chk("t5_rvalid", ext_rvalid, 1'b1);
        chk("t5_rdata", ext_rdata, 32'h6060_6060);
        reset = 1'b1;
        step();
        chk("t6_state", arb_state, 2'd0);
        chk("t6_hold", core_hold, 1'b0);
        chk("t6_rvalid", ext_rvalid, 1'b0);
        chk("t6_perr", proto_err, 1'b0);
        reset = 1'b0;
        drive_ext(0, 0, '0, '0);
        step();
        step();
        chk("t5_memword", bmem[9'h050], 32'hAAAA_5555);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
